// File: rtl/vga_timing_if.sv
// Shared VGA timing bus carried from the timing generator to every draw stage.
// Counts are 11 bits, so totals up to 2048 pixels/lines per period fit.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA timing generator: pixel/line counters, sync and blanking
// decode, plus one-cycle vertical-blank and frame-wrap strobes.
module vga_timing #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  vga_if.out   vga_out,
  output logic vblnk_start,
  output logic frame_start
);

  localparam int CW      = 11;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
    $error("vga_timing: every timing parameter must be at least 1");
  end

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblnk_q, hblnk_d;
  logic          vblnk_q, vblnk_d;
  logic          vblnk_start_q, vblnk_start_d;
  logic          frame_start_q, frame_start_d;
  logic          h_wrap;
  logic          v_wrap;

  // Flags are decoded from the next-state counts so every output is a flop
  // and all of them move together with the counters on the same edge.
  always_comb begin
    // NOTE: every signal gets a value on every path here; a missing default
    // in a combinational block silently infers a latch.
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
    end

    hblnk_d = (hcount_d >= H_ACT);
    vblnk_d = (vcount_d >= V_ACT);
    hsync_d = ((hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END)) ? HSYNC_POL : !HSYNC_POL;
    vsync_d = ((vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END)) ? VSYNC_POL : !VSYNC_POL;

    vblnk_start_d = (hcount_d == '0) && (vcount_d == V_ACT);
    // Only a genuine wrap flags a frame; the (0,0) left by reset does not.
    frame_start_d = h_wrap && v_wrap;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= !HSYNC_POL;
      vsync_q       <= !VSYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      vblnk_start_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      vblnk_start_q <= vblnk_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vblnk_start    = vblnk_start_q;
  assign frame_start    = frame_start_q;

endmodule
